// File: rtl/gpio_frame_capture.sv
// GPIO frame capture: packs one frame of strobed samples into PACK_W words and streams them out of a FIFO.
// Define GPIO_CAPTURE_CONTINUOUS_EN to re-arm capture automatically after each frame.
module gpio_frame_capture #(
  parameter int DATA_W     = 1,
  parameter int PACK_W     = 8,
  parameter int FRAME_LEN  = 27360,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             start,
  input  logic [DATA_W-1:0]                in_data,
  input  logic                             in_valid,
  output logic [PACK_W-1:0]                out_data,
  output logic                             out_valid,
  input  logic                             out_ready,
  output logic                             out_last,
  output logic                             busy,
  output logic                             frame_done,
  output logic                             overflow,
  output logic [$clog2(FRAME_LEN+1)-1:0]   sample_count
);
  localparam int K  = PACK_W / DATA_W;
  localparam int KW = (K > 1) ? $clog2(K) : 1;
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(FRAME_LEN + 1);

  typedef enum logic [1:0] {S_IDLE, S_CAPTURE, S_FLUSH, S_DONE} state_t;

  state_t              r_state;
  logic [PACK_W-1:0]   r_mem [FIFO_DEPTH];
  logic [FIFO_DEPTH-1:0] r_mem_last;
  logic [AW:0]         r_wr_ptr;
  logic [AW:0]         r_rd_ptr;
  logic [PACK_W-1:0]   r_pack;
  logic [KW-1:0]       r_idx;
  logic [CW-1:0]       r_count;
  logic                r_overflow;

  logic                w_empty;
  logic                w_full;
  logic                w_pop;
  logic                w_take;
  logic                w_last_sample;
  logic                w_push;
  logic                w_push_ok;
  logic                w_drained;
  logic [AW:0]         w_level;
  logic [PACK_W-1:0]   w_word;

  assign w_empty       = (r_wr_ptr == r_rd_ptr);
  assign w_full        = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                         (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
  assign w_pop         = !w_empty && out_ready;
  assign w_take        = (r_state == S_CAPTURE) && in_valid;
  assign w_last_sample = (r_count == CW'(FRAME_LEN - 1));
  assign w_push        = w_take && ((r_idx == KW'(K - 1)) || w_last_sample);
  assign w_push_ok     = w_push && (!w_full || w_pop);
  assign w_level       = r_wr_ptr - r_rd_ptr;
  // Leave FLUSH on the edge that pops the final word so frame_done follows the pop directly.
  assign w_drained     = w_empty || ((w_level == (AW+1)'(1)) && w_pop);

  // Packer slots above the current sample are still zero, which gives the padding for a short last word.
  always_comb begin
    w_word = r_pack;
    w_word[r_idx*DATA_W +: DATA_W] = in_data;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_mem_last <= '0;
      r_pack     <= '0;
      r_idx      <= '0;
      r_count    <= '0;
      r_overflow <= 1'b0;
      for (int i = 0; i < FIFO_DEPTH; i++) r_mem[i] <= '0;
    end else begin
      if (w_pop) r_rd_ptr <= r_rd_ptr + 1'b1;
      if (w_push_ok) begin
        r_mem[r_wr_ptr[AW-1:0]]      <= w_word;
        r_mem_last[r_wr_ptr[AW-1:0]] <= w_last_sample;
        r_wr_ptr                     <= r_wr_ptr + 1'b1;
      end
      if (w_push && !w_push_ok) r_overflow <= 1'b1;

      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_state    <= S_CAPTURE;
            r_count    <= '0;
            r_pack     <= '0;
            r_idx      <= '0;
            r_overflow <= 1'b0;
          end
        end
        S_CAPTURE: begin
          if (in_valid) begin
            r_count <= r_count + 1'b1;
            if (w_push) begin
              r_pack <= '0;
              r_idx  <= '0;
            end else begin
              r_pack <= w_word;
              r_idx  <= r_idx + 1'b1;
            end
            if (w_last_sample) r_state <= S_FLUSH;
          end
        end
        S_FLUSH: begin
          if (w_drained) r_state <= S_DONE;
        end
        S_DONE: begin
`ifdef GPIO_CAPTURE_CONTINUOUS_EN
          r_state <= S_CAPTURE;
          r_count <= '0;
          r_pack  <= '0;
          r_idx   <= '0;
`else
          r_state <= S_IDLE;
`endif
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign out_data     = r_mem[r_rd_ptr[AW-1:0]];
  assign out_valid    = !w_empty;
  assign out_last     = !w_empty && r_mem_last[r_rd_ptr[AW-1:0]];
  assign busy         = (r_state != S_IDLE);
  assign frame_done   = (r_state == S_DONE);
  assign overflow     = r_overflow;
  assign sample_count = r_count;
endmodule
